// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one external combinational ALU.
// The FSM grants a request, holds its operands on the ALU for one cycle, and
// registers the result into a response slot that is released by valid/ready.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned FUNC_SIZE = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [DATA_SIZE-1:0] i_req0_a,
  input  logic [DATA_SIZE-1:0] i_req0_b,
  input  logic [FUNC_SIZE-1:0] i_req0_func,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [DATA_SIZE-1:0] i_req1_a,
  input  logic [DATA_SIZE-1:0] i_req1_b,
  input  logic [FUNC_SIZE-1:0] i_req1_func,
  output logic [DATA_SIZE-1:0] o_alu_a,
  output logic [DATA_SIZE-1:0] o_alu_b,
  output logic [FUNC_SIZE-1:0] o_alu_func,
  input  logic [DATA_SIZE-1:0] i_alu_out,
  input  logic                 i_alu_zero,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_SIZE-1:0] o_rsp_data,
  output logic                 o_rsp_zero,
  output logic                 o_rsp_id
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e               state_q;
  logic [DATA_SIZE-1:0] a_q, b_q, rsp_data_q;
  logic [FUNC_SIZE-1:0] func_q;
  logic                 id_q, rsp_id_q, rsp_zero_q, rsp_valid_q;

  logic grant_en, pick0, gnt0, gnt1, gnt_any;

`ifdef ALU_ARB_RR_EN
  // last_q = id of the most recent grant; 1 after reset so requester 0 wins first
  logic last_q;
  assign pick0 = last_q;
`else
  assign pick0 = 1'b1;
`endif

  // Grant decode: only in grant cycles, single winner, never during reset
  always_comb begin
    grant_en = i_rst_n & ((state_q == StIdle) | ((state_q == StResp) & i_rsp_ready));
    gnt0     = grant_en & i_req0_valid & (~i_req1_valid | pick0);
    gnt1     = grant_en & i_req1_valid & ~gnt0;
    gnt_any  = gnt0 | gnt1;
  end

  // Sequencer FSM with operand latch, response slot and arbitration pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      func_q      <= '0;
      id_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      // gnt_any is only ever high in StIdle or a releasing StResp
      if (gnt_any) begin
        a_q    <= gnt1 ? i_req1_a    : i_req0_a;
        b_q    <= gnt1 ? i_req1_b    : i_req0_b;
        func_q <= gnt1 ? i_req1_func : i_req0_func;
        id_q   <= gnt1;
`ifdef ALU_ARB_RR_EN
        last_q <= gnt1;
`endif
      end
      unique case (state_q)
        StIdle: begin
          if (gnt_any) state_q <= StExec;
        end
        StExec: begin
          rsp_data_q  <= i_alu_out;
          rsp_zero_q  <= i_alu_zero;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= gnt_any ? StExec : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign o_alu_a      = a_q;
  assign o_alu_b      = b_q;
  assign o_alu_func   = func_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_zero   = rsp_zero_q;
  assign o_rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of single operations from idle, then
// hand-written sequences for back-to-back arbitration, backpressure and reset.
module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 11;

  logic          clk, rst_n;
  logic          v0, v1, rdy0, rdy1, rsp_ready;
  logic [DW-1:0] a0, b0, a1, b1;
  logic [FW-1:0] f0, f1;
  logic [DW-1:0] alu_a, alu_b, alu_out, rsp_data;
  logic [FW-1:0] alu_func;
  logic          alu_zero, rsp_valid, rsp_zero, rsp_id;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.DATA_SIZE(DW), .FUNC_SIZE(FW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (v0),
    .o_req0_ready (rdy0),
    .i_req0_a     (a0),
    .i_req0_b     (b0),
    .i_req0_func  (f0),
    .i_req1_valid (v1),
    .o_req1_ready (rdy1),
    .i_req1_a     (a1),
    .i_req1_b     (b1),
    .i_req1_func  (f1),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_func   (alu_func),
    .i_alu_out    (alu_out),
    .i_alu_zero   (alu_zero),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_zero   (rsp_zero),
    .o_rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU driven from the arbiter's operand outputs
  always_comb begin
    alu_out = '0;
    case (alu_func)
      11'd0: alu_out = alu_a + alu_b;
      11'd1: alu_out = alu_a - alu_b;
      11'd2: alu_out = alu_a & alu_b;
      11'd3: alu_out = alu_a | alu_b;
      11'd4: alu_out = alu_a ^ alu_b;
      11'd5: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v0, v1;
    logic [DW-1:0] a0, b0, a1, b1;
    logic [FW-1:0] f0, f1;
    logic          exp_id;
    logic [DW-1:0] exp_data;
    logic          exp_zero;
  } vec_t;

  vec_t vecs[8];
  logic exp_id;

  initial begin
    // {v0,v1,a0,b0,a1,b1,f0,f1,id,data,zero}
    vecs[0] = '{1, 0, 5,     7,     0,     0,     0, 0, 0, 12,    0};
    vecs[1] = '{0, 1, 0,     0,     9,     9,     0, 1, 1, 0,     1};
    vecs[2] = '{1, 0, 3,     4,     0,     0,     5, 0, 0, 1,     0};
    vecs[3] = '{0, 1, 0,     0,     3,     4,     0, 7, 1, 0,     1};
    vecs[4] = '{1, 0, 'hF0,  'h3C,  0,     0,     2, 0, 0, 'h30,  0};
    vecs[5] = '{0, 1, 0,     0,     'hF0,  'h0F,  0, 3, 1, 'hFF,  0};
    // both valid, previous grant was req1: req0 wins in either mode
    vecs[6] = '{1, 1, 1,     2,     10,    3,     0, 1, 0, 3,     0};
`ifdef ALU_ARB_RR_EN
    vecs[7] = '{1, 1, 1,     2,     10,    3,     0, 1, 1, 7,     0};
`else
    vecs[7] = '{1, 1, 1,     2,     10,    3,     0, 1, 0, 3,     0};
`endif

    rst_n = 1'b0; v0 = 0; v1 = 0; rsp_ready = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; f0 = '0; f1 = '0;
    #1;
    check("rst_ready0", 32'(rdy0), 0);
    check("rst_ready1", 32'(rdy1), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_func", 32'(alu_func), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_zero_id", 32'({rsp_zero, rsp_id}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one operation at a time starting from idle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v0 = vecs[i].v0; v1 = vecs[i].v1;
      a0 = vecs[i].a0; b0 = vecs[i].b0; f0 = vecs[i].f0;
      a1 = vecs[i].a1; b1 = vecs[i].b1; f1 = vecs[i].f1;
      #1;
      check($sformatf("v%0d_ready0", i), 32'(rdy0), 32'(!vecs[i].exp_id));
      check($sformatf("v%0d_ready1", i), 32'(rdy1), 32'(vecs[i].exp_id));
      @(posedge clk);
      #1 v0 = 0; v1 = 0;
      @(negedge clk);
      check($sformatf("v%0d_exec_valid", i), 32'(rsp_valid), 0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(rsp_valid), 1);
      check($sformatf("v%0d_data", i), rsp_data, vecs[i].exp_data);
      check($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].exp_zero));
      check($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vecs[i].exp_id));
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check($sformatf("v%0d_idle_valid", i), 32'(rsp_valid), 0);
    end

    // Both valid continuously, consumer always ready
    begin
      int rsp_cnt;
      int last_cyc;
      rsp_cnt = 0;
      last_cyc = 0;
      @(negedge clk);
      v0 = 1; a0 = 1; b0 = 1; f0 = 0;
      v1 = 1; a1 = 2; b1 = 1; f1 = 1;
      rsp_ready = 1;
      for (int cyc = 0; cyc < 12 && rsp_cnt < 4; cyc++) begin
        #1;
        check("bb_both_ready", 32'(rdy0 & rdy1), 0);
        if (rsp_valid) begin
`ifdef ALU_ARB_RR_EN
          exp_id = rsp_cnt[0];
`else
          exp_id = 1'b0;
`endif
          check($sformatf("bb_id%0d", rsp_cnt), 32'(rsp_id), 32'(exp_id));
          check($sformatf("bb_data%0d", rsp_cnt), rsp_data, exp_id ? 32'd1 : 32'd2);
          check($sformatf("bb_cycle%0d", rsp_cnt), cyc - last_cyc, (rsp_cnt == 0) ? 2 : 2);
          last_cyc = cyc;
          rsp_cnt++;
        end
        if (rsp_cnt == 4) begin
          v0 = 0; v1 = 0;
        end
        @(negedge clk);
      end
      check("bb_rsp_count", rsp_cnt, 4);
      rsp_ready = 0;
      #1 check("bb_idle_valid", 32'(rsp_valid), 0);
    end

    // Backpressure: XOR result held while req1 waits
    @(negedge clk);
    v0 = 1; a0 = 'hF0; b0 = 'hFF; f0 = 4;
    #1 check("bp_ready0", 32'(rdy0), 1);
    @(posedge clk);
    #1 v0 = 0;
    v1 = 1; a1 = 2; b1 = 2; f1 = 0;
    @(negedge clk);
    check("bp_exec_ready1", 32'(rdy1), 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 1);
      check($sformatf("bp_data%0d", i), rsp_data, 'h0F);
      check($sformatf("bp_noready%0d", i), 32'({rdy0, rdy1}), 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    #1 check("bp_same_cycle_grant", 32'({rdy0, rdy1}), 1);
    @(posedge clk);
    #1 v1 = 0; rsp_ready = 0;
    @(negedge clk);
    check("bp_exec_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    check("bp2_valid", 32'(rsp_valid), 1);
    check("bp2_data", rsp_data, 4);
    check("bp2_id_zero", 32'({rsp_id, rsp_zero}), 2);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // Reset during EXEC
    v0 = 1; a0 = 5; b0 = 7; f0 = 0;
    @(posedge clk);
    #1 v0 = 0;
    @(negedge clk);
    check("rx_alu_a_before", alu_a, 5);
    #2 rst_n = 0;
    #1;
    check("rx_alu_a", alu_a, 0);
    check("rx_alu_b", alu_b, 0);
    check("rx_rsp_data", rsp_data, 0);
    check("rx_rsp_id", 32'(rsp_id), 0);
    check("rx_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1;

    // Reset during RESP; last grant before reset is req0
    @(negedge clk);
    v0 = 1; a0 = 'hAA; b0 = 'h55; f0 = 3;
    @(posedge clk);
    #1 v0 = 0;
    @(negedge clk);
    @(negedge clk);
    check("rr_valid_before", 32'(rsp_valid), 1);
    check("rr_data_before", rsp_data, 'hFF);
    #2 rst_n = 0;
    #1;
    check("rr_rsp_valid", 32'(rsp_valid), 0);
    check("rr_rsp_data", rsp_data, 0);
    check("rr_alu_a_b", alu_a | alu_b, 0);
    check("rr_alu_func", 32'(alu_func), 0);
    @(negedge clk);
    rst_n = 1;

    // After reset, req0 wins when both valid
    @(negedge clk);
    v0 = 1; a0 = 3; b0 = 3; f0 = 0;
    v1 = 1; a1 = 8; b1 = 1; f1 = 1;
    #1;
    check("post_rst_ready0", 32'(rdy0), 1);
    check("post_rst_ready1", 32'(rdy1), 0);
    @(posedge clk);
    #1 v0 = 0; v1 = 0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_id", 32'(rsp_id), 0);
    check("post_rst_data", rsp_data, 6);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer that shares one combinational ALU between the main execute datapath (requester 0) and a secondary unit such as a branch/compare engine (requester 1). It grants one request at a time, latches its operands, drives the ALU for one cycle, and registers the result into a response slot. The response slot is held under a valid/ready handshake until it is consumed. It sits between the requesters and the ALU's operand, function, result and zero ports.

## Interface
- DATA_SIZE, 32, operand/result width
- FUNC_SIZE, 11, ALU function-code width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req0_valid / i_req1_valid  in  1  request present
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle
- i_req0_a, i_req0_b / i_req1_a, i_req1_b  in  DATA_SIZE  operands
- i_req0_func / i_req1_func  in  FUNC_SIZE  ALU code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT; other codes give a result of 0
- o_alu_a, o_alu_b  out  DATA_SIZE  operands to the ALU
- o_alu_func  out  FUNC_SIZE  function to the ALU
- i_alu_out  in  DATA_SIZE  ALU result
- i_alu_zero  in  1  ALU zero flag
- o_rsp_valid  out  1  response held
- i_rsp_ready  in  1  consumer takes the response
- o_rsp_data  out  DATA_SIZE  registered result
- o_rsp_zero  out  1  registered zero flag
- o_rsp_id  out  1  requester that owns the response

## Operation
- FSM states:
  - IDLE: waiting for a request; the response slot is empty.
  - EXEC: the operand registers drive the ALU.
  - RESP: the response is held.
- IDLE:
  - If any valid is high, grant one requester: its ready is 1 for this cycle only.
  - Latch its a, b, func and id into the operand registers, then go to EXEC.
  - If no valid is high, stay in IDLE.
- EXEC:
  - Capture i_alu_out to o_rsp_data, i_alu_zero to o_rsp_zero, and the latched id to o_rsp_id.
  - Go to RESP.
- RESP:
  - o_rsp_valid is 1.
  - Without i_rsp_ready, stay in RESP; data, zero and id are held stable.
  - With i_rsp_ready and a valid request pending, grant it in the same cycle (ready pulse, operands latched) and go to EXEC.
  - With i_rsp_ready and no request pending, go to IDLE.
- o_reqN_ready is combinational. It is high only in a grant cycle (IDLE, or RESP with i_rsp_ready), only for the winner, and never for both requesters.
- The o_alu_a, o_alu_b and o_alu_func outputs always reflect the operand registers. They change only on a grant.
- A requester must hold valid and its operands stable until it sees ready. Deasserting valid before a grant withdraws the request with no side effects.
- Arbitration when both requesters are valid depends on ALU_ARB_RR_EN (see Configuration). A single valid requester always wins.
- Reset takes effect immediately, from any state: state becomes IDLE, all registers clear, and an in-flight operation or held response is discarded.

## Timing
- Reset values:
  - o_req0_ready and o_req1_ready are 0 (no valid requests during reset).
  - o_alu_a, o_alu_b, o_alu_func, o_rsp_valid, o_rsp_data, o_rsp_zero and o_rsp_id are all 0.
  - The round-robin pointer resets to "last grant = 1", so requester 0 wins first.
- Latency: grant in cycle N (ALU evaluates in N+1), o_rsp_valid in N+2.
- Throughput: with the consumer always ready, one operation every 2 cycles (back-to-back grants from RESP). From IDLE, the first operation takes 3 cycles.
- Simultaneous events:
  - A response handshake and a new grant in the same cycle are legal.
  - The new id and data appear two cycles later.
  - o_rsp_valid drops for exactly one cycle (the EXEC cycle).
- o_rsp_valid falls on the clock edge after the handshake. It never falls while i_rsp_ready is low.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration. When both requesters are valid, the one not granted last wins. The pointer updates on every grant.
- ALU_ARB_RR_EN undefined: fixed priority. Requester 0 always wins, and the pointer logic is removed.

## Test plan
- Single ADD on req0 from IDLE:
  - Stimulus: a=5, b=7, func=0.
  - Required: ready0 pulses in cycle N; rsp_valid in N+2 with data=12, zero=0, id=0.
- SUB giving zero on req1:
  - Stimulus: a=9, b=9, func=1.
  - Required: data=0, zero=1, id=1. SLT with a=3, b=4 gives data=1. func=7 gives data=0, zero=1.
- Both requesters valid continuously, consumer always ready:
  - Required with ALU_ARB_RR_EN: ids alternate 0,1,0,1; an operation every 2 cycles.
  - Required without ALU_ARB_RR_EN: all ids are 0 and req1 is never granted.
- Backpressure:
  - Stimulus: hold i_rsp_ready=0 for 5 cycles while the response is XOR 0xF0^0xFF.
  - Required: data stays 0x0F and no ready pulses occur. On the ready cycle, a pending request is granted in the same cycle.
- Reset mid-operation:
  - Stimulus: assert i_rst_n=0 asynchronously during EXEC, then during RESP.
  - Required: outputs go to 0 immediately, without waiting for a clock edge. After release, the first grant goes to req0 when both requesters are valid.
